// File: rtl/axis_cam_if.sv
// axis_cam_if: AXI4-Stream beat bus leaving the camera capture block
interface axis_cam_if #(parameter int BYTES_PER_BEAT = 2);
  logic [8*BYTES_PER_BEAT-1:0] tdata;
  logic tvalid, tready, tlast, tuser;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_cam_capture.sv
// axis_cam_capture: packs DVP camera bytes into AXI4-Stream beats, with frame
// skipping, per-line/per-frame sanity checks and sticky error flags.
module axis_cam_capture #(
  parameter int BYTES_PER_BEAT = 2,
  parameter int IMAGE_WIDTH = 800,
  parameter int IMAGE_HEIGHT = 300
) (
  input  logic        PCLK,
  input  logic        RESETB,
  input  logic [7:0]  DIN,
  input  logic        HREF,
  input  logic        VSYNC,
  input  logic        enable,
  input  logic [3:0]  skip_n,
  input  logic        err_clr,
  axis_cam_if.master  m_axis,
  output logic        busy,
  output logic        err_line,
  output logic        err_frame,
  output logic        err_ovf,
  output logic [15:0] frame_cnt
);
  localparam int DW = 8*BYTES_PER_BEAT;
  localparam int IW = BYTES_PER_BEAT > 1 ? $clog2(BYTES_PER_BEAT) : 1;
  localparam int BW = $clog2(IMAGE_WIDTH + 2);
  localparam int LW = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_BEAT - 1);
  localparam logic [BW-1:0] WIDTH = BW'(IMAGE_WIDTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(IMAGE_WIDTH - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(IMAGE_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, WAIT, ACTIVE, SKIP, DROP} state_t;
  state_t state_q, state_d;
  logic href_q, vsync_q, busy_q;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] pack_q, pack_d, beat, tdata_q, tdata_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d, done_q, done_d;
  logic [3:0] skip_cnt_q, skip_cnt_d;
  logic err_line_q, err_frame_q, err_ovf_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic fs, le, accept, start, set_line, set_frame, set_ovf;
  assign fs = VSYNC & ~vsync_q;
  assign le = ~HREF & href_q;
  assign accept = tvalid_q & m_axis.tready;
  // done_q marks that the frame's tuser beat is loaded; capture pauses until it is accepted
  always_comb begin
    state_d = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    idx_d = idx_q;
    pack_d = pack_q;
    skip_cnt_d = skip_cnt_q;
    done_d = done_q;
    frame_cnt_d = frame_cnt_q;
    tdata_d = tdata_q;
    tvalid_d = tvalid_q & ~m_axis.tready;
    tlast_d = tlast_q & ~m_axis.tready;
    tuser_d = tuser_q & ~m_axis.tready;
    start = 1'b0;
    set_line = 1'b0;
    set_frame = 1'b0;
    set_ovf = 1'b0;
    beat = pack_q;
    beat[8*idx_q +: 8] = DIN;
    case (state_q)
      IDLE: state_d = enable ? WAIT : IDLE;
      WAIT: begin
        if (!enable) state_d = IDLE;
        else start = fs;
      end
      SKIP: begin
        if (!enable) state_d = IDLE;
        else if (fs && skip_cnt_q == 4'd0) start = 1'b1;
        else if (fs) skip_cnt_d = skip_cnt_q - 4'd1;
      end
      DROP: begin
        if (fs && enable) start = 1'b1;
        else if (fs) state_d = IDLE;
      end
      ACTIVE: begin
        if (done_q && accept && tuser_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d = skip_n != 4'd0 ? SKIP : enable ? WAIT : IDLE;
        end else if (fs && !done_q) begin
          set_frame = 1'b1;
          start = enable;
          state_d = enable ? ACTIVE : IDLE;
        end else if (!done_q && le) begin
          set_line = byte_cnt_q != WIDTH;
          state_d = byte_cnt_q != WIDTH ? DROP : ACTIVE;
          line_cnt_d = line_cnt_q + LW'(1);
          byte_cnt_d = '0;
          idx_d = '0;
        end else if (!done_q && HREF) begin
          byte_cnt_d = byte_cnt_q + BW'(byte_cnt_q <= WIDTH);
          idx_d = idx_q == LAST_IDX ? '0 : idx_q + IW'(1);
          pack_d = beat;
          if (idx_q == LAST_IDX && tvalid_q && !m_axis.tready) begin
            set_ovf = 1'b1;
            state_d = DROP;
          end else if (idx_q == LAST_IDX) begin
            tdata_d = beat;
            tvalid_d = 1'b1;
            tlast_d = byte_cnt_q == LAST_BYTE;
            tuser_d = byte_cnt_q == LAST_BYTE && line_cnt_q == LAST_LINE;
            done_d = byte_cnt_q == LAST_BYTE && line_cnt_q == LAST_LINE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = ACTIVE;
      skip_cnt_d = skip_n;
      byte_cnt_d = '0;
      line_cnt_d = '0;
      idx_d = '0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge PCLK) begin
    if (!RESETB) begin
      state_q <= IDLE;
      href_q <= 1'b0;
      vsync_q <= 1'b0;
      busy_q <= 1'b0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      idx_q <= '0;
      pack_q <= '0;
      skip_cnt_q <= '0;
      done_q <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
      err_line_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      href_q <= HREF;
      vsync_q <= VSYNC;
      busy_q <= state_d != IDLE;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      idx_q <= idx_d;
      pack_q <= pack_d;
      skip_cnt_q <= skip_cnt_d;
      done_q <= done_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      err_line_q <= (err_line_q & ~err_clr) | set_line;
      err_frame_q <= (err_frame_q & ~err_clr) | set_frame;
      err_ovf_q <= (err_ovf_q & ~err_clr) | set_ovf;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign m_axis.tdata = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast = tlast_q;
  assign m_axis.tuser = tuser_q;
  assign busy = busy_q;
  assign err_line = err_line_q;
  assign err_frame = err_frame_q;
  assign err_ovf = err_ovf_q;
  assign frame_cnt = frame_cnt_q;
endmodule
